// File: rtl/int_ctrl.sv
// Priority interrupt controller: edge-latched requests, mask, intr/inta/eoi handshake, non-nested service.
// Latency: 2 clocks from the first high irq sample to intr; intr holds until inta, the in-service line holds until eoi.
module int_ctrl #(
    parameter int         N_IRQ    = 8,
    parameter logic [7:0] VEC_BASE = 8'h50
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [N_IRQ-1:0] irq,
    input  logic             mask_we,
    input  logic [N_IRQ-1:0] mask_wdata,
    input  logic             eoi,
    input  logic             inta,
    output logic             intr,
    output logic [7:0]       vector,
    output logic [N_IRQ-1:0] pending,
    output logic [N_IRQ-1:0] in_service,
    output logic [N_IRQ-1:0] mask
);

    localparam int IW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SERV = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [N_IRQ-1:0] irq_q;
    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] avail;
    logic [N_IRQ-1:0] pending_nxt;
    logic [N_IRQ-1:0] ack_clr;
    logic [N_IRQ-1:0] idx_oh;
    logic [N_IRQ-1:0] in_service_nxt;
    logic [IW-1:0]    sel;
    logic [IW-1:0]    idx, idx_nxt;
    logic             intr_nxt;
    logic [7:0]       vector_nxt;

    assign rise  = irq & ~irq_q;
    assign avail = pending & ~mask;

    // Scan from the top down so the lowest set index wins.
    always_comb begin
        sel = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (avail[i]) begin
                sel = IW'(i);
            end
        end
    end

    always_comb begin
        idx_oh = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            idx_oh[i] = (idx == IW'(i));
        end
    end

    always_comb begin
        state_nxt      = state;
        intr_nxt       = intr;
        vector_nxt     = vector;
        idx_nxt        = idx;
        in_service_nxt = in_service;
        ack_clr        = '0;
        case (state)
            IDLE: begin
                if (|avail) begin
                    state_nxt  = REQ;
                    intr_nxt   = 1'b1;
                    vector_nxt = VEC_BASE + 8'(sel);
                    idx_nxt    = sel;
                end
            end
            REQ: begin
                if (inta) begin
                    state_nxt      = SERV;
                    intr_nxt       = 1'b0;
                    ack_clr        = idx_oh;
                    in_service_nxt = idx_oh;
                end
            end
            SERV: begin
                if (eoi) begin
                    state_nxt      = IDLE;
                    in_service_nxt = '0;
                end
            end
            default: begin
                state_nxt      = IDLE;
                intr_nxt       = 1'b0;
                in_service_nxt = '0;
            end
        endcase
    end

    // A fresh edge on the line being acknowledged must survive the clear.
    assign pending_nxt = (pending & ~ack_clr) | rise;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state      <= IDLE;
            irq_q      <= '0;
            pending    <= '0;
            mask       <= '1;
            intr       <= 1'b0;
            vector     <= 8'h00;
            idx        <= '0;
            in_service <= '0;
        end else begin
            state      <= state_nxt;
            irq_q      <= irq;
            pending    <= pending_nxt;
            if (mask_we) begin
                mask <= mask_wdata;
            end
            intr       <= intr_nxt;
            vector     <= vector_nxt;
            idx        <= idx_nxt;
            in_service <= in_service_nxt;
        end
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed handshake sequences with a vector scoreboard checked on every intr rise.
module tb_int_ctrl;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [7:0] irq = 8'h00;
    logic       mask_we = 1'b0;
    logic [7:0] mask_wdata = 8'h00;
    logic       eoi = 1'b0;
    logic       inta = 1'b0;
    logic       intr;
    logic [7:0] vector;
    logic [7:0] pending;
    logic [7:0] in_service;
    logic [7:0] mask;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] sb[$];
    logic       intr_prev = 1'b0;

    int_ctrl #(.N_IRQ(8), .VEC_BASE(8'h50)) dut (
        .clk(clk),
        .clr(clr),
        .irq(irq),
        .mask_we(mask_we),
        .mask_wdata(mask_wdata),
        .eoi(eoi),
        .inta(inta),
        .intr(intr),
        .vector(vector),
        .pending(pending),
        .in_service(in_service),
        .mask(mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr = 1'b1;
        step(2);
        clr = 1'b0;
        step(1);
    endtask

    // Every rising edge of intr must match the next queued vector.
    always @(posedge clk) begin
        #1;
        if (intr && !intr_prev) begin
            if (sb.size() == 0) begin
                chk("unexpected_intr_vector", vector, 8'hxx);
            end else begin
                chk("sb_vector", vector, sb.pop_front());
            end
        end
        intr_prev = intr;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        do_reset();
        chk("rst_intr", 8'(intr), 8'h00);
        chk("rst_vector", vector, 8'h00);
        chk("rst_mask", mask, 8'hFF);
        chk("rst_pending", pending, 8'h00);
        chk("rst_in_service", in_service, 8'h00);

        // Masked request latches but never raises intr
        irq = 8'h08;
        step(1);
        chk("masked_pending", pending, 8'h08);
        chk("masked_intr0", 8'(intr), 8'h00);
        step(3);
        chk("masked_intr1", 8'(intr), 8'h00);
        irq = 8'h00;
        do_reset();
        chk("rerst_pending", pending, 8'h00);

        // Single request on line 2
        mask_we = 1'b1; mask_wdata = 8'h00;
        step(1);
        mask_we = 1'b0;
        chk("mask_write", mask, 8'h00);
        irq = 8'h04; sb.push_back(8'h52);
        step(1);
        irq = 8'h00;
        chk("l2_pending", pending, 8'h04);
        chk("l2_intr_e0", 8'(intr), 8'h00);
        step(1);
        chk("l2_intr_e1", 8'(intr), 8'h01);
        chk("l2_vector", vector, 8'h52);
        step(1);
        chk("l2_intr_hold", 8'(intr), 8'h01);
        inta = 1'b1;
        step(1);
        inta = 1'b0;
        chk("l2_ack_intr", 8'(intr), 8'h00);
        chk("l2_ack_isr", in_service, 8'h04);
        chk("l2_ack_pending", pending, 8'h00);
        chk("l2_ack_vector", vector, 8'h52);
        eoi = 1'b1;
        step(1);
        eoi = 1'b0;
        chk("l2_eoi_isr", in_service, 8'h00);
        chk("l2_eoi_vector", vector, 8'h52);

        // Simultaneous lines 5 and 1: priority then turnaround
        irq = 8'h22; sb.push_back(8'h51); sb.push_back(8'h55);
        step(1);
        irq = 8'h00;
        step(1);
        chk("pri_intr", 8'(intr), 8'h01);
        chk("pri_vector", vector, 8'h51);
        inta = 1'b1;
        step(1);
        inta = 1'b0;
        chk("pri_isr1", in_service, 8'h02);
        chk("pri_pending1", pending, 8'h20);
        eoi = 1'b1;
        step(1);
        eoi = 1'b0;
        chk("pri_idle_intr", 8'(intr), 8'h00);
        step(1);
        chk("pri_turn_intr", 8'(intr), 8'h01);
        chk("pri_vector5", vector, 8'h55);
        inta = 1'b1;
        step(1);
        inta = 1'b0;
        chk("pri_isr5", in_service, 8'h20);
        eoi = 1'b1;
        step(1);
        eoi = 1'b0;

        // Selection frozen in REQ despite new edge and mask write
        irq = 8'h10; sb.push_back(8'h54);
        step(1);
        irq = 8'h00;
        step(1);
        chk("frz_intr", 8'(intr), 8'h01);
        irq = 8'h01; mask_we = 1'b1; mask_wdata = 8'h10; sb.push_back(8'h50);
        step(1);
        irq = 8'h00; mask_we = 1'b0;
        chk("frz_vector0", vector, 8'h54);
        chk("frz_mask", mask, 8'h10);
        chk("frz_pending", pending, 8'h11);
        step(2);
        chk("frz_vector1", vector, 8'h54);
        chk("frz_intr_hold", 8'(intr), 8'h01);
        inta = 1'b1;
        step(1);
        inta = 1'b0;
        chk("frz_isr4", in_service, 8'h10);
        eoi = 1'b1;
        step(1);
        eoi = 1'b0;
        step(1);
        chk("frz_l0_intr", 8'(intr), 8'h01);
        chk("frz_l0_vector", vector, 8'h50);
        inta = 1'b1;
        step(1);
        inta = 1'b0;
        chk("frz_isr0", in_service, 8'h01);
        eoi = 1'b1;
        step(1);
        eoi = 1'b0;

        // Stray inta in IDLE, stray eoi in REQ
        inta = 1'b1;
        step(1);
        inta = 1'b0;
        chk("ign_inta_intr", 8'(intr), 8'h00);
        chk("ign_inta_isr", in_service, 8'h00);
        irq = 8'h08; sb.push_back(8'h53);
        step(1);
        irq = 8'h00;
        step(1);
        chk("ign_req_intr", 8'(intr), 8'h01);
        eoi = 1'b1;
        step(1);
        eoi = 1'b0;
        chk("ign_eoi_intr", 8'(intr), 8'h01);
        chk("ign_eoi_isr", in_service, 8'h00);
        chk("ign_eoi_vector", vector, 8'h53);

        // New edge on the acknowledged line in the same cycle: set wins
        irq = 8'h08; inta = 1'b1; sb.push_back(8'h53);
        step(1);
        irq = 8'h00; inta = 1'b0;
        chk("setwin_pending", pending, 8'h08);
        chk("setwin_isr", in_service, 8'h08);
        eoi = 1'b1;
        step(1);
        eoi = 1'b0;
        step(1);
        chk("setwin_reintr", 8'(intr), 8'h01);
        inta = 1'b1;
        step(1);
        inta = 1'b0;

        // Asynchronous clear while in service with lines pending
        irq = 8'h22;
        step(1);
        irq = 8'h00;
        chk("pre_clr_pending", pending, 8'h22);
        chk("pre_clr_isr", in_service, 8'h08);
        #2;
        clr = 1'b1;
        #1;
        chk("aclr_intr", 8'(intr), 8'h00);
        chk("aclr_pending", pending, 8'h00);
        chk("aclr_isr", in_service, 8'h00);
        chk("aclr_mask", mask, 8'hFF);
        chk("aclr_vector", vector, 8'h00);
        step(2);
        clr = 1'b0;
        step(3);
        chk("post_clr_intr", 8'(intr), 8'h00);
        chk("sb_drained", 8'(sb.size()), 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/int_ctrl.md
# int_ctrl

Priority interrupt controller for the Citrus pipelined CPU. Collects up to N_IRQ peripheral interrupt request lines, latches their rising edges as pending, applies a software-writable mask, and presents the highest-priority unmasked request to the CPU through the `intr`/`inta` handshake together with an 8-bit `vector`. It is the requesting end of the CPU's interrupt interface. It holds one interrupt in service until the CPU's handler signals end-of-interrupt.

## Interface
- `N_IRQ`, default 8: number of request lines, 1..8.
- `VEC_BASE`, default 8'h50: vector for line 0; line i gets `VEC_BASE + i`, 8-bit wrap.

Ports:
- `clk`  in  1: clock; all state updates on the rising edge.
- `clr`  in  1: reset, asynchronous, active-high.
- `irq`  in  N_IRQ: peripheral request lines; a rising edge requests service; synchronous to `clk`.
- `mask_we`  in  1: when high, `mask` loads `mask_wdata` at the clock edge.
- `mask_wdata`  in  N_IRQ: new mask value; 1 = line disabled.
- `eoi`  in  1: end-of-interrupt pulse from the handler.
- `inta`  in  1: interrupt acknowledge from the CPU.
- `intr`  out  1: interrupt request to the CPU; registered.
- `vector`  out  8: vector of the requested or in-service line; registered.
- `pending`  out  N_IRQ: latched, not-yet-acknowledged requests.
- `in_service`  out  N_IRQ: one-hot; the line currently being serviced.
- `mask`  out  N_IRQ: current mask register.

## Operation
- Edge detect:
  - `irq_q` is a register holding `irq` from the previous cycle. It resets to 0.
  - `pending[i]` sets when `irq[i] & ~irq_q[i]`. This happens regardless of mask.
  - A line held high through reset release therefore registers one edge on the first clock.
- Priority: the lowest index has the highest priority. `sel` is the lowest i with `pending[i] & ~mask[i]`.
- FSM states: IDLE, REQ, SERV.
  - IDLE → REQ when any `pending & ~mask` bit is set. At the same edge, `intr` ← 1 and `vector` ← `VEC_BASE + sel`, and the selected index is latched.
  - REQ → SERV when `inta` = 1. At that edge:
    - `intr` ← 0.
    - `pending[idx]` clears.
    - `in_service` ← one-hot(idx).
    - `vector` holds.
  - SERV → IDLE when `eoi` = 1. At that edge `in_service` ← 0. `vector` keeps its last value.
- Handling is non-nested. A new request is never raised while a line is in REQ or SERV, whatever its priority.
- The selection is frozen in REQ. Mask writes and new higher-priority edges during REQ do not change `vector` and do not cancel `intr`.
- Ignored events:
  - `inta` outside REQ.
  - `eoi` outside SERV.
- Simultaneous new edge and acknowledge-clear on the same line in one cycle: set wins, and `pending` stays 1.
- Mask writes take effect for selection on the next IDLE evaluation.
- Reset values:
  - FSM = IDLE.
  - `intr` = 0, `vector` = 8'h00.
  - `pending` = 0, `in_service` = 0, `irq_q` = 0.
  - `mask` = all ones (all lines disabled).
- Asserting `clr` mid-handshake returns everything to the reset values immediately. Requests that were pending are lost.

## Timing
- Edge E0 samples `irq[i]` rising, so `pending[i]` = 1 after E0.
- At E1, with the FSM in IDLE and the line unmasked, `intr` = 1 and `vector` is valid after E1. Latency is 2 clocks from the first high sample to `intr`.
- `intr` and `vector` stay stable until `inta` is sampled high. `intr` falls on that same edge.
- `vector` is valid from the rise of `intr` until the next IDLE → REQ transition.
- After `eoi`, the FSM spends at least 1 cycle in IDLE. The next `intr` can rise at the following edge, so the turnaround is 2 clocks from `eoi` sampling to the next `intr`.
- `mask_we`: `mask` is updated after the edge where `mask_we` is sampled high.

## Test plan
- Reset, then hold `clr` low. Check `intr` = 0, `vector` = 8'h00 and `mask` = 8'hFF. Raise `irq[3]` while masked: `pending[3]` = 1 and `intr` stays 0.
- Write mask 8'h00, then pulse `irq[2]`. Check `intr` rises 2 clocks after `irq` and `vector` = 8'h52. Assert `inta` for 1 cycle: `intr` = 0, `in_service` = 8'h04, `pending[2]` = 0. Pulse `eoi`: `in_service` = 0.
- Raise `irq[5]` and `irq[1]` on the same cycle. Check `vector` = 8'h51 first. After `inta` and `eoi`, check `intr` rises again with `vector` = 8'h55.
- During REQ for line 4, pulse `irq[0]` and write mask 8'h10. Check `vector` stays 8'h54 until `inta`. After `eoi`, check line 0 is served with `vector` = 8'h50.
- Pulse `inta` in IDLE and `eoi` in REQ. Check there is no state change.
- Assert `clr` while in SERV with `pending` = 8'h22. Check `intr`, `pending` and `in_service` are all 0 immediately (asynchronously) and `mask` = 8'hFF.
